// File: rtl/ex_result_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ex_result_stage_pkg                                     |
// | Purpose  : Shared types for the EX result buffer: buffer state     |
// |            encoding, NZCV bit positions and the buffered entry     |
// |            record.                                                 |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package ex_result_stage_pkg;

  // Widths of the entry record; the top-level parameters must match these.
  localparam int unsigned EX_RESULT_W = 32;
  localparam int unsigned EX_RD_W     = 5;

  // Bit positions of each flag inside a 4-bit {N,Z,C,V} vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Occupancy of the two-entry in-order buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // One buffered ALU result together with its writeback attributes.
  typedef struct packed {
    logic [EX_RESULT_W-1:0] result;
    logic [EX_RD_W-1:0]     rd;
    logic                   we;
    logic [3:0]             flags;
    logic                   set_flags;
  } entry_t;

  // Pack individual ALU flags into {N,Z,C,V} order.
  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage : ex_result_stage_pkg
`default_nettype wire

// File: rtl/ex_result_stage_nzcv_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : nzcv_reg                                                |
// | Purpose  : Architectural NZCV flag register. Loads d_i when en_i   |
// |            is high; clears to zero on reset.                       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module nzcv_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] nzcv_q;
  logic [3:0] nzcv_d;

  // Hold the current flags unless an update is requested.
  always_comb begin
    nzcv_d = nzcv_q;
    if (en_i) begin
      nzcv_d = d_i;
    end
  end

  // Flag storage, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv_q <= 4'b0000;
    end else begin
      nzcv_q <= nzcv_d;
    end
  end

  assign q_o = nzcv_q;

endmodule : nzcv_reg
`default_nettype wire

// File: rtl/ex_result_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ex_result_stage                                         |
// | Purpose  : Two-entry in-order buffer between the ALU and           |
// |            writeback. Presents the oldest entry on out_* and on    |
// |            the forwarding port. Optional macro EX_NZCV_REG_EN adds |
// |            an architectural NZCV register updated on pop.          |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module ex_result_stage
  import ex_result_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Result,
  input  logic             Carry,
  input  logic             OverFlow,
  input  logic             Zero,
  input  logic             Negative,
  input  logic [RD_W-1:0]  rd,
  input  logic             we,
  input  logic             set_flags,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_we,
  output logic [3:0]       out_flags,
  output logic             fwd_valid,
  output logic [RD_W-1:0]  fwd_rd,
  output logic [WIDTH-1:0] fwd_data
`ifdef EX_NZCV_REG_EN
  ,
  output logic [3:0]       nzcv
`endif
);

  // The entry record is sized by the package; reject mismatched overrides.
  if (WIDTH != EX_RESULT_W || RD_W != EX_RD_W) begin : g_width_check
    $error("ex_result_stage: WIDTH/RD_W must match ex_result_stage_pkg");
  end

  state_e state_q;
  state_e state_d;
  logic   in_ready_q;

  entry_t head_q;
  entry_t head_d;
  entry_t tail_q;
  entry_t tail_d;
  entry_t new_entry;

  logic push;
  logic pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  // Capture the incoming ALU result; writes to register 0 are suppressed.
  always_comb begin
    new_entry.result    = Result;
    new_entry.rd        = rd;
    new_entry.we        = we && (rd != '0);
    new_entry.flags     = pack_nzcv(Negative, Zero, Carry, OverFlow);
    new_entry.set_flags = set_flags;
  end

  // State register; in_ready is registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // Next-state logic; flush overrides any push or pop in the same cycle.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop) begin
            state_d = ST_FULL;
          end else if (!push && pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL:  if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Output decode of the buffer state.
  always_comb begin
    out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
    in_ready  = in_ready_q;
  end

  // Slot steering: head always holds the oldest entry, tail the younger.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      ST_EMPTY: if (push) head_d = new_entry;
      ST_ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d = new_entry;
        end
      end
      ST_FULL:  if (pop) head_d = tail_q;
      default:  ;
    endcase
  end

  // Payload storage carries no reset; validity comes from the state.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;
  assign out_we     = head_q.we;
  assign out_flags  = head_q.flags;

  assign fwd_valid  = out_valid && head_q.we;
  assign fwd_rd     = head_q.rd;
  assign fwd_data   = head_q.result;

`ifdef EX_NZCV_REG_EN
  logic flag_upd;

  // Only a real pop (not one cancelled by flush) may commit flags.
  assign flag_upd = pop && !flush && head_q.set_flags;

  nzcv_reg u_nzcv_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (flag_upd),
    .d_i  (head_q.flags),
    .q_o  (nzcv)
  );
`endif

endmodule : ex_result_stage
`default_nettype wire

// File: doc/ex_result_stage.md
EX_RESULT_STAGE -- requirements
Module: ex_result_stage

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of ALU result.
REQ-002 Parameter RD_W, default 5: destination-register index width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  ALU result presented this cycle.
REQ-007 in_ready  out  1  stage can accept; registered, independent of out_ready.
REQ-008 Result  in  WIDTH  ALU result.
REQ-009 Carry, OverFlow, Zero, Negative  in  1 each  ALU flags.
REQ-010 rd  in  RD_W  destination register; we  in  1  write enable; set_flags  in  1  instruction updates NZCV.
REQ-011 flush  in  1  discard all buffered entries.
REQ-012 out_valid  out  1; out_ready  in  1  writeback handshake.
REQ-013 out_result  out  WIDTH; out_rd  out  RD_W; out_we  out  1; out_flags  out  4 {N,Z,C,V} of head entry.
REQ-014 fwd_valid  out  1; fwd_rd  out  RD_W; fwd_data  out  WIDTH  forwarding of head entry to operand muxes.

Function
REQ-015 Stage SHALL be a 2-entry in-order buffer with states EMPTY, ONE, FULL.
REQ-016 Push when in_valid&&in_ready; pop when out_valid&&out_ready.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL.
REQ-018 out_valid SHALL be 1 in ONE and FULL; out_* reflect oldest entry.
REQ-019 Latency: entry pushed at edge N SHALL appear on out_* after edge N (visible cycle N+1) when buffer was EMPTY.
REQ-020 Transitions: EMPTY->ONE push; ONE->FULL push only; ONE->EMPTY pop only; ONE->ONE push+pop; FULL->ONE pop.
REQ-021 Simultaneous push and pop in ONE SHALL keep order: new entry becomes head after current head leaves.
REQ-022 Entry captured with rd==0 SHALL store we=0.
REQ-023 fwd_valid SHALL equal out_valid&&out_we; fwd_rd/fwd_data equal out_rd/out_result.
REQ-024 flush SHALL move to EMPTY on next edge, overriding push and pop that cycle; NZCV unchanged by flushed entries.
REQ-025 Payload registers need no reset; only state and flags reset.

Reset
REQ-026 On rst: state EMPTY, out_valid 0, in_ready 1, fwd_valid 0, nzcv 4'b0000.
REQ-027 Reset asserted mid-transfer SHALL discard all entries immediately; no pop is reported.

Configuration
REQ-028 Macro EX_NZCV_REG_EN defined: additional output nzcv (4 bits) SHALL be a architectural flag register updated with head entry's flags on pop when its set_flags=1.
REQ-029 Without EX_NZCV_REG_EN: no nzcv port, set_flags ignored, out_flags still carried per entry.

Structure
REQ-030 Shared package SHALL hold state encoding (EMPTY/ONE/FULL), flag-bit index constants N=3,Z=2,C=1,V=0, and the entry record typedef {result, rd, we, flags, set_flags}.
REQ-031 Flag register SHALL be a sub-module nzcv_reg (clk, rst, update enable, 4-bit in, 4-bit out).

Verification
REQ-032 Reset then push Result=32'h3, rd=5, we=1 with out_ready=1 -> out_valid next cycle, out_result=3, out_rd=5, fwd_valid=1, EMPTY after pop.
REQ-033 out_ready=0, push 32'hA then 32'hB -> in_ready=0 after second push; third push ignored; release out_ready -> outputs A then B in order.
REQ-034 State ONE, push 32'h7 and pop same cycle -> stays ONE, out_result becomes 7.
REQ-035 Push with rd=0, we=1 -> out_we=0, fwd_valid=0.
REQ-036 FULL, assert flush with in_valid=1 -> EMPTY next cycle, out_valid=0, in_ready=1.
REQ-037 With EX_NZCV_REG_EN: push 32'h0-32'h0 result 0, Zero=1, Carry=1, set_flags=1, pop -> nzcv=4'b0110; entry with set_flags=0 popped -> nzcv unchanged.
